// File: rtl/i4004_bus_pkg.sv
// Shared definitions for the i4004 ROM bus master.
//   NIBBLE_W / ADDR_W : bus nibble width and ROM address width
//   state_t           : instruction-cycle phase; the encoding doubles as the
//                       value shown on the debug display
//   req_t             : request fields latched on accept
package i4004_bus_pkg;
  localparam int NIBBLE_W = 4;
  localparam int ADDR_W   = 12;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_X3   = 4'd1,
    ST_A1   = 4'd2,
    ST_A2   = 4'd3,
    ST_A3   = 4'd4,
    ST_M1   = 4'd5,
    ST_M2   = 4'd6,
    ST_X1   = 4'd7,
    ST_X2   = 4'd8
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic                io_en;
    logic [NIBBLE_W-1:0] io_data;
  } req_t;
endpackage

// File: rtl/i4004_phase_timer.sv
// Bus phase divider. Counts 0..PHASE_DIV-1 and flags the last CLK of a phase.
//   CLK   : system clock
//   RESET : async active-high reset
//   clear : hold the count at 0 (bus idle)
//   step  : high on the last CLK of the current phase
module i4004_phase_timer #(
  parameter int PHASE_DIV = 1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  output logic step
);
  localparam logic [7:0] LAST = 8'(PHASE_DIV - 1);

  logic [7:0] cnt;

  assign step = (cnt == LAST);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)              cnt <= '0;
    else if (clear || step) cnt <= '0;
    else                    cnt <= cnt + 8'd1;
  end
endmodule

// File: rtl/i4004_rom_bus_master.sv
// CPU-side initiator for the 4-bit multiplexed i4001 ROM bus. Each accepted
// request runs one instruction cycle X3(SYNC) A1 A2 A3 M1 M2 X1 X2 and
// returns the fetched byte; an optional I/O nibble is driven in X2.
//   CLK, RESET            : clock, async active-high reset
//   req_valid/req_ready   : request handshake
//   req_addr              : [11:8] chip, [7:0] byte
//   req_io_en/req_io_data : drive nibble in X2
//   rsp_valid/rsp_data    : one-CLK pulse with {OPR, OPA}
//   SYNC, CM_ROM          : ROM control lines
//   bus_out/bus_oe/bus_in : multiplexed data bus (external tristate)
//   phase                 : current state encoding for the debug display
module i4004_rom_bus_master
  import i4004_bus_pkg::*;
#(
  parameter int PHASE_DIV = 1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_io_en,
  input  logic [NIBBLE_W-1:0] req_io_data,
  output logic                rsp_valid,
  output logic [7:0]          rsp_data,
  output logic                SYNC,
  output logic                CM_ROM,
  output logic [NIBBLE_W-1:0] bus_out,
  output logic                bus_oe,
  input  logic [NIBBLE_W-1:0] bus_in,
  output logic [3:0]          phase
);
  state_t              state, state_nx;
  req_t                rq;
  logic [NIBBLE_W-1:0] opr, opa;
  logic                step, accept;

  i4004_phase_timer #(.PHASE_DIV(PHASE_DIV)) u_timer (
    .CLK   (CLK),
    .RESET (RESET),
    .clear (state == ST_IDLE),
    .step  (step)
  );

  // Ready never looks at req_valid, so the requester can't form a loop.
  assign req_ready = (state == ST_IDLE) || (state == ST_X2 && step);
  assign accept    = req_valid && req_ready;
  assign phase     = state;
  assign rsp_data  = {opr, opa};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rq        <= '0;
      opr       <= '0;
      opa       <= '0;
      rsp_valid <= 1'b0;
    end else begin
      if (accept) rq <= '{addr: req_addr, io_en: req_io_en, io_data: req_io_data};
      if (state == ST_M1 && step) opr <= bus_in;
      if (state == ST_M2 && step) opa <= bus_in;
      // Registered on the M2->X1 edge: high for exactly the first CLK of X1.
      rsp_valid <= (state == ST_M2) && step;
    end
  end

  always_comb begin
    state_nx = state;
    SYNC     = 1'b0;
    CM_ROM   = 1'b0;
    bus_out  = '0;
    bus_oe   = 1'b0;
    unique case (state)
      ST_IDLE: if (accept) state_nx = ST_X3;
      ST_X3: begin
        SYNC = 1'b1;
        if (step) state_nx = ST_A1;
      end
      ST_A1: begin
        bus_out = rq.addr[3:0];
        bus_oe  = 1'b1;
        if (step) state_nx = ST_A2;
      end
      ST_A2: begin
        bus_out = rq.addr[7:4];
        bus_oe  = 1'b1;
        if (step) state_nx = ST_A3;
      end
      ST_A3: begin
        bus_out = rq.addr[11:8];
        bus_oe  = 1'b1;
        CM_ROM  = 1'b1;
        if (step) state_nx = ST_M1;
      end
      ST_M1: if (step) state_nx = ST_M2;
      ST_M2: if (step) state_nx = ST_X1;
      ST_X1: if (step) state_nx = ST_X2;
      ST_X2: begin
        bus_out = rq.io_data;
        bus_oe  = rq.io_en;
        CM_ROM  = rq.io_en;
        // A new accept here chains straight into the next SYNC.
        if (step) state_nx = accept ? ST_X3 : ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end
endmodule
